// File: rtl/uart_rx_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_core -- 8N1 UART receiver feeding a first-word-fall-through FIFO (rev 1.0)
// ---------------------------------------------------------------------------
module uart_rx_core #(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic [7:0]           data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 clear_i,
  output logic                 busy_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);
  localparam logic [CW-1:0]        FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 sync_q, rx_s_q, rx_prev_q;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 push, set_ferr, expire;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 pop, full, wr_en, drop;

  assign div_eff = (divisor_i < DIV_MIN) ? DIV_MIN : divisor_i;
  assign expire  = (cnt_q == CNT_ONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    set_ferr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // rx_prev_q stays low through a break, so a low stop bit cannot retrigger
        if (!rx_s_q && rx_prev_q) begin
          cnt_d   = div_eff >> 1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (expire) begin
          if (rx_s_q) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = div_eff;
            bit_d   = 3'd0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (expire) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = div_eff;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (expire) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            push = 1'b1;
          end else begin
            set_ferr = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign valid_o = (count_q != '0);
  assign pop     = valid_o & ready_i;
  assign full    = (count_q == FIFO_FULL);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign wr_en   = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(wr_en);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(wr_en) - CW'(pop);
    frame_err_d = set_ferr | (frame_err_q & ~clear_i);
    overrun_d   = drop | (overrun_q & ~clear_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= rx_i;
      rx_s_q      <= sync_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign data_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_core -- directed scoreboard bench for uart_rx_core (rev 1.0)
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst_n_i, rx_i, ready_i, clear_i;
  logic [15:0] divisor_i;
  logic [7:0]  data_o;
  logic        valid_o, frame_err_o, overrun_o, busy_o;

  logic [7:0]  exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          rise_off;

  uart_rx_core #(.DIV_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .rx_i       (rx_i),
    .divisor_i  (divisor_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .clear_i    (clear_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: every accepted pop is compared with the oldest expected byte
  always @(negedge clk) begin
    if (rst_n_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: actual=%0h required=none", data_o);
      end else begin
        chk("pop_data", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"},  {24'h0, data_o}, 32'h0);
    chk({tag, "_valid"}, {31'h0, valid_o}, 32'h0);
    chk({tag, "_ferr"},  {31'h0, frame_err_o}, 32'h0);
    chk({tag, "_ovr"},   {31'h0, overrun_o}, 32'h0);
    chk({tag, "_busy"},  {31'h0, busy_o}, 32'h0);
  endtask

  // One 8N1 frame of d clocks per bit; optional ready pulse / reset pulse at a cycle offset
  task automatic send_frame(input logic [7:0] b, input logic stop, input int d,
                            input int rdy_at, input int rst_at, input int tail_low);
    logic [9:0] fr;
    fr       = {stop, b, 1'b0};
    rise_off = -1;
    for (int off = 0; off < 10 * d; off++) begin
      rx_i = fr[off / d];
      if (rdy_at >= 0 && off == rdy_at) ready_i = 1'b1;
      if (rdy_at >= 0 && off == rdy_at + 1) ready_i = 1'b0;
      if (rst_at >= 0 && off == rst_at) begin
        rst_n_i = 1'b0;
        #1;
        chk_reset_vals("midframe_rst");
      end
      if (rst_at >= 0 && off == rst_at + 1) rst_n_i = 1'b1;
      tick();
      if (valid_o && rise_off < 0) rise_off = off + 1;
    end
    repeat (tail_low) tick();
    rx_i = 1'b1;
    repeat (4) tick();
  endtask

  task automatic drain();
    ready_i = 1'b1;
    for (int i = 0; i < 20 && valid_o; i++) tick();
    ready_i = 1'b0;
    chk("drain_valid_low", {31'h0, valid_o}, 32'h0);
    chk("scoreboard_empty", exp_q.size(), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: actual=no_finish required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n_i   = 1'b0;
    rx_i      = 1'b1;
    ready_i   = 1'b0;
    clear_i   = 1'b0;
    divisor_i = 16'd16;
    repeat (3) tick();
    chk_reset_vals("in_reset");
    rst_n_i = 1'b1;
    repeat (5) tick();
    chk("idle_busy", {31'h0, busy_o}, 32'h0);

    // D=16, 0x55, valid stop, no consumer
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 16, -1, -1, 0);
    chk("latency_55", rise_off, 32'd155);
    chk("head_55", {24'h0, data_o}, 32'h55);
    chk("ferr_55", {31'h0, frame_err_o}, 32'h0);
    chk("ovr_55", {31'h0, overrun_o}, 32'h0);
    drain();

    // 5-clock low glitch: START sample at E+8 sees high
    rx_i = 1'b0;
    repeat (5) tick();
    chk("glitch_busy_mid", {31'h0, busy_o}, 32'h1);
    rx_i = 1'b1;
    repeat (5) tick();
    chk("glitch_busy_last", {31'h0, busy_o}, 32'h1);
    tick();
    chk("glitch_busy_low", {31'h0, busy_o}, 32'h0);
    chk("glitch_valid", {31'h0, valid_o}, 32'h0);
    chk("glitch_ferr", {31'h0, frame_err_o}, 32'h0);

    // 0xA3 with a low stop bit held as a break
    send_frame(8'hA3, 1'b0, 16, -1, -1, 32);
    chk("ferr_set", {31'h0, frame_err_o}, 32'h1);
    chk("ferr_no_push", {31'h0, valid_o}, 32'h0);
    chk("ferr_busy", {31'h0, busy_o}, 32'h0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("ferr_cleared", {31'h0, frame_err_o}, 32'h0);

    // Five bytes into a four-entry FIFO with no consumer
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 16, -1, -1, 0);
    end
    chk("ovr_set", {31'h0, overrun_o}, 32'h1);
    chk("ovr_head", {24'h0, data_o}, 32'h01);
    drain();

    // Full FIFO with a pop coincident with the push
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("ovr_cleared", {31'h0, overrun_o}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 16, -1, -1, 0);
    end
    exp_q.push_back(8'h05);
    send_frame(8'h05, 1'b1, 16, 2 + 16 / 2 + 9 * 16, -1, 0);
    chk("full_pop_push_ovr", {31'h0, overrun_o}, 32'h0);
    chk("full_pop_push_head", {24'h0, data_o}, 32'h02);
    drain();

    // divisor 2 clamps to D=4; second frame is abandoned by reset during bit 3
    divisor_i = 16'd2;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 4, -1, -1, 0);
    chk("d4_valid", {31'h0, valid_o}, 32'h1);
    chk("d4_data", {24'h0, data_o}, 32'hFF);
    send_frame(8'hFF, 1'b1, 4, -1, 17, 0);
    exp_q.delete();
    chk_reset_vals("after_rst_frame");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, width of the bit-period divisor.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port divisor_i  input  DIV_WIDTH  clocks per bit, static while busy_o=1.
REQ-007 SHALL have port data_o  output  8  head-of-FIFO byte.
REQ-008 SHALL have port valid_o  output  1  FIFO non-empty.
REQ-009 SHALL have port ready_i  input  1  consumer pop; pop occurs when valid_o&ready_i.
REQ-010 SHALL have port frame_err_o  output  1  sticky, stop bit sampled low.
REQ-011 SHALL have port overrun_o  output  1  sticky, byte dropped because FIFO full.
REQ-012 SHALL have port clear_i  input  1  synchronous clear of both sticky flags.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL pass rx_i through a 2-flop synchronizer (reset value 1) before any use; rx_s denotes its output.
REQ-015 SHALL implement FSM IDLE, START, DATA, STOP, with an effective divisor D = max(divisor_i, 4).
REQ-016 IDLE: on rx_s=0 with previous rx_s=1 (edge cycle E), SHALL load the bit counter with D/2 (integer division) and go to START.
REQ-017 START: at counter expiry (E + D/2), SHALL sample rx_s; 1 -> glitch, return to IDLE with no flag; 0 -> reload D, bit index 0, go to DATA.
REQ-018 DATA: SHALL sample rx_s every D clocks at E + D/2 + (k+1)*D for k=0..7, shifting LSB first; after bit 7 SHALL reload D and go to STOP.
REQ-019 STOP: at E + D/2 + 9*D, SHALL sample rx_s; 1 -> push byte; 0 -> discard byte, set frame_err_o; both go to IDLE.
REQ-020 After a framing error, IDLE SHALL require rx_s=1 for at least one clock before accepting a new edge (break condition yields exactly one frame_err, no repeated frames).
REQ-021 Push SHALL be registered: valid_o/data_o reflect the byte in the cycle after the stop sample, i.e. rx_i falling edge + 3 + D/2 + 9*D clocks.
REQ-022 FIFO SHALL be first-word-fall-through; data_o stable while valid_o=1 and no pop.
REQ-023 Push while full and no pop SHALL drop the new byte and set overrun_o; stored bytes unchanged.
REQ-024 Simultaneous push and pop while full SHALL accept the push with no overrun.
REQ-025 Simultaneous push and pop while empty SHALL not pop (valid_o was 0); byte appears next cycle.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-027 clear_i SHALL clear flags next cycle; a set event coincident with clear_i SHALL win (flag stays 1).
REQ-028 Pop with valid_o=0 SHALL be ignored.

Reset
REQ-029 rst_n_i low SHALL immediately force: FSM IDLE, synchronizer flops 1, counters 0, FIFO empty, data_o 0x00, valid_o 0, frame_err_o 0, overrun_o 0, busy_o 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; after release a new frame SHALL require a fresh 1->0 edge on rx_s.

Verification
REQ-031 D=16, send 0x55 with valid stop, ready_i=0 -> valid_o rises 155 clocks after rx_i falls, data_o=0x55, flags 0.
REQ-032 D=16, rx_i low pulse of 5 clocks -> back to IDLE at START sample, FIFO empty, no flags, busy_o low by E+9.
REQ-033 D=16, send 0xA3 with stop bit low -> no push, frame_err_o=1; clear_i pulse -> frame_err_o=0 next cycle.
REQ-034 ready_i=0, send 5 bytes 0x01..0x05 -> FIFO holds 0x01..0x04, overrun_o=1; pop 4 times -> 0x01,0x02,0x03,0x04 in order, then valid_o=0.
REQ-035 FIFO full, ready_i=1 in the push cycle -> no overrun; subsequent pops yield 0x02,0x03,0x04,new byte.
REQ-036 divisor_i=2 -> treated as D=4; 0xFF received correctly; rst_n_i pulsed during bit 3 -> no byte, all outputs at reset values.
